seq_restoring_divider: RTL

//  Iterative restoring divider: the inverse of the 8x8 Wallace multiplier in the MAC datapath.

---
 rtl/mac_pkg.sv | 15 +
 rtl/seq_restoring_divider_if.sv | 24 ++
 rtl/div_step.sv | 23 ++
 rtl/seq_restoring_divider.sv | 105 ++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared MAC datapath widths and divider FSM state encoding
package mac_pkg;

   // Operand width of the MAC multiplier and its product width
   localparam int MAC_AW = 8;
   localparam int MAC_PW = 16;

   // Divider control states
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/seq_restoring_divider_if.sv
// rtl/seq_restoring_divider_if.sv - start/busy/done request bus of the divider
interface seq_restoring_divider_if #(
   parameter int DW = 16,
   parameter int VW = 8
);
   logic          start;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic          busy;
   logic          done;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          div_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_zero
   );
endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring trial-subtract step
module div_step #(
   parameter int VW = 8
) (
   input  logic [VW-1:0] pr,
   input  logic          next_bit,
   input  logic [VW-1:0] divisor,
   output logic [VW-1:0] pr_next,
   output logic          q_bit
);
   // The partial remainder is always below the divisor, so the shifted value
   // fits in VW+1 bits and the trial's top bit acts as its sign.
   logic [VW:0] shifted;
   logic [VW:0] trial;

   // Trial subtract; keep the difference when non-negative, else restore
   always_comb begin
      shifted = {pr, next_bit};
      trial   = shifted - {1'b0, divisor};
      q_bit   = ~trial[VW];
      pr_next = q_bit ? trial[VW-1:0] : shifted[VW-1:0];
   end
endmodule

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - iterative restoring divider, one quotient bit per clock
module seq_restoring_divider
   import mac_pkg::*;
#(
   parameter int DW = MAC_PW,
   parameter int VW = MAC_AW
) (
   input  logic                   clk,
   input  logic                   rst,
   seq_restoring_divider_if.slave bus
);
   localparam int CW = $clog2(DW);

   div_state_t    state;
   div_state_t    state_nx;
   logic [CW-1:0] count;
   logic [VW-1:0] pr;
   logic [DW-1:0] q;
   logic [VW-1:0] dvs;
   logic [VW-1:0] pr_nx;
   logic          q_bit;
   logic          accept;
   logic          done_r;
   logic          div_zero_r;
   logic [DW-1:0] quotient_r;
   logic [VW-1:0] remainder_r;

   assign accept = (state == S_IDLE) && bus.start;

   div_step #(.VW(VW)) u_step (
      .pr       (pr),
      .next_bit (q[DW-1]),
      .divisor  (dvs),
      .pr_next  (pr_nx),
      .q_bit    (q_bit)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // Next-state logic: zero divisor skips the iteration entirely
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: if (bus.start) state_nx = (bus.divisor == '0) ? S_DONE : S_RUN;
         S_RUN:  if (count == '0) state_nx = S_DONE;
         S_DONE: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Working registers: operand capture and one shift/subtract per RUN cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         pr    <= '0;
         q     <= '0;
         dvs   <= '0;
      end else if (accept) begin
         count <= CW'(DW - 1);
         pr    <= '0;
         q     <= bus.dividend;
         dvs   <= bus.divisor;
      end else if (state == S_RUN) begin
         count <= count - 1'b1;
         pr    <= pr_nx;
         q     <= {q[DW-2:0], q_bit};
      end
   end

   // Result registers: written only on entry to DONE so intermediates never leak
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         quotient_r  <= '0;
         remainder_r <= '0;
      end else if (accept && bus.divisor == '0) begin
         quotient_r  <= '1;
         remainder_r <= bus.dividend[VW-1:0];
      end else if (state == S_RUN && count == '0) begin
         quotient_r  <= {q[DW-2:0], q_bit};
         remainder_r <= pr_nx;
      end
   end

   // Done pulse and divide-by-zero flag follow the DONE state by one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_r     <= 1'b0;
         div_zero_r <= 1'b0;
      end else begin
         done_r <= (state == S_DONE);
         if (accept)                div_zero_r <= 1'b0;
         else if (state == S_DONE)  div_zero_r <= (dvs == '0);
      end
   end

   assign bus.busy      = (state == S_RUN) || (state == S_DONE);
   assign bus.done      = done_r;
   assign bus.quotient  = quotient_r;
   assign bus.remainder = remainder_r;
   assign bus.div_zero  = div_zero_r;
endmodule
